// File: rtl/ring_peak_detector.sv
// Per-ring hysteresis peak tracker on tagged {channel, data} samples.
// Emits one registered event per completed peak: ring, max channel, peak, width.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   s_valid/s_ready   sample handshake; s_channel, s_data sample tag and value
//   thresh, hyst      entry threshold and hysteresis below it for exit
//   m_valid/m_ready   event handshake; m_ring, m_channel, m_peak, m_width
//   active_rings      bit r set while ring r is inside a peak
module ring_peak_detector #(
    parameter int DATA_W    = 10,
    parameter int CH_W      = 6,
    parameter int NUM_RINGS = 8,
    parameter int WIDTH_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [CH_W-1:0]      s_channel,
    input  logic [DATA_W-1:0]    s_data,
    input  logic [DATA_W-1:0]    thresh,
    input  logic [DATA_W-1:0]    hyst,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [2:0]           m_ring,
    output logic [CH_W-1:0]      m_channel,
    output logic [DATA_W-1:0]    m_peak,
    output logic [WIDTH_W-1:0]   m_width,
    output logic [NUM_RINGS-1:0] active_rings
);

    localparam int RING_W = $clog2(NUM_RINGS);

    typedef enum logic {
        IDLE    = 1'b0,
        IN_PEAK = 1'b1
    } state_t;

    state_t             st_q    [NUM_RINGS];
    state_t             st_d    [NUM_RINGS];
    logic [DATA_W-1:0]  max_q   [NUM_RINGS];
    logic [DATA_W-1:0]  max_d   [NUM_RINGS];
    logic [CH_W-1:0]    maxch_q [NUM_RINGS];
    logic [CH_W-1:0]    maxch_d [NUM_RINGS];
    logic [WIDTH_W-1:0] width_q [NUM_RINGS];
    logic [WIDTH_W-1:0] width_d [NUM_RINGS];

    logic [RING_W-1:0]  ring;
    logic [DATA_W-1:0]  lower;
    logic               accept;
    logic               exit_fire;

    assign ring   = s_channel[CH_W-1 -: RING_W];
    // Clamp so a large hysteresis never wraps the exit level.
    assign lower  = (thresh > hyst) ? thresh - hyst : '0;
    assign accept = s_valid & s_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_RINGS; r++) begin
                st_q[r]    <= IDLE;
                max_q[r]   <= '0;
                maxch_q[r] <= '0;
                width_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_RINGS; r++) begin
                st_q[r]    <= st_d[r];
                max_q[r]   <= max_d[r];
                maxch_q[r] <= maxch_d[r];
                width_q[r] <= width_d[r];
            end
        end
    end

    // Next state: only the ring addressed by an accepted sample moves.
    always_comb begin
        exit_fire = 1'b0;
        for (int r = 0; r < NUM_RINGS; r++) begin
            st_d[r]    = st_q[r];
            max_d[r]   = max_q[r];
            maxch_d[r] = maxch_q[r];
            width_d[r] = width_q[r];
        end
        if (accept) begin
            unique case (st_q[ring])
                IDLE: begin
                    if (s_data > thresh) begin
                        st_d[ring]    = IN_PEAK;
                        max_d[ring]   = s_data;
                        maxch_d[ring] = s_channel;
                        width_d[ring] = WIDTH_W'(1);
                    end
                end
                IN_PEAK: begin
                    if (s_data > lower) begin
                        if (!(&width_q[ring])) begin
                            width_d[ring] = width_q[ring] + WIDTH_W'(1);
                        end
                        // Strict compare: ties keep the earlier channel.
                        if (s_data > max_q[ring]) begin
                            max_d[ring]   = s_data;
                            maxch_d[ring] = s_channel;
                        end
                    end else begin
                        st_d[ring] = IDLE;
                        exit_fire  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        s_ready      = !m_valid | m_ready;
        active_rings = '0;
        for (int r = 0; r < NUM_RINGS; r++) begin
            active_rings[r] = (st_q[r] == IN_PEAK);
        end
    end

    // Single-entry event register; exit_fire can only occur when it
    // is empty or being drained, so no event is ever overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_ring    <= '0;
            m_channel <= '0;
            m_peak    <= '0;
            m_width   <= '0;
        end else if (exit_fire) begin
            m_valid   <= 1'b1;
            m_ring    <= 3'(ring);
            m_channel <= maxch_q[ring];
            m_peak    <= max_q[ring];
            m_width   <= width_q[ring];
        end else if (m_ready) begin
            m_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ring_peak_detector.sv
// Directed testbench for ring_peak_detector.
// Inputs change 1 time unit after posedge; outputs sampled on negedge.
module tb_ring_peak_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [5:0] s_channel;
    logic [9:0] s_data;
    logic [9:0] thresh;
    logic [9:0] hyst;
    logic       m_valid;
    logic       m_ready;
    logic [2:0] m_ring;
    logic [5:0] m_channel;
    logic [9:0] m_peak;
    logic [7:0] m_width;
    logic [7:0] active_rings;

    int checks   = 0;
    int failures = 0;

    // {ring, channel, peak, width}
    typedef logic [26:0] ev_t;
    ev_t evq[$];

    ring_peak_detector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_channel    (s_channel),
        .s_data       (s_data),
        .thresh       (thresh),
        .hyst         (hyst),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_ring       (m_ring),
        .m_channel    (m_channel),
        .m_peak       (m_peak),
        .m_width      (m_width),
        .active_rings (active_rings)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            evq.push_back({m_ring, m_channel, m_peak, m_width});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] ch, input logic [9:0] d);
        int n;
        n = 0;
        s_channel = ch;
        s_data    = d;
        s_valid   = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL send_timeout ch=%h data=%0d", ch, d);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_channel = '0;
        s_data    = '0;
        thresh    = 10'd510;
        hyst      = 10'd16;
        m_ready   = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_m_valid got=%b exp=0", m_valid);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_s_ready got=%b exp=1", s_ready);
        end
        checks++;
        if (active_rings !== 8'h00) begin
            failures++;
            $display("FAIL reset_active got=%h exp=00", active_rings);
        end
        checks++;
        if ({m_ring, m_channel, m_peak, m_width} !== 27'd0) begin
            failures++;
            $display("FAIL reset_fields got=%h exp=0",
                     {m_ring, m_channel, m_peak, m_width});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        evq.delete();
        send(6'h11, 10'd500);
        send(6'h11, 10'd520);
        send(6'h11, 10'd600);
        send(6'h11, 10'd550);
        checks++;
        if (active_rings !== 8'h04) begin
            failures++;
            $display("FAIL t1_active got=%h exp=04", active_rings);
        end
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL t1_early_valid got=%b exp=0", m_valid);
        end
        send(6'h11, 10'd490);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1) begin
            failures++;
            $display("FAIL t1_latency got=%b exp=1", m_valid);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL t1_valid_clear got=%b exp=0", m_valid);
        end
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL t1_count got=%0d exp=1", evq.size());
        end else if (evq[0] !== {3'd2, 6'h11, 10'd600, 8'd3}) begin
            failures++;
            $display("FAIL t1_event got=%h exp=%h", evq[0],
                     {3'd2, 6'h11, 10'd600, 8'd3});
        end
        idle(1);
    endtask

    task automatic test_boundary();
        evq.delete();
        send(6'h05, 10'd510);
        checks++;
        if (active_rings !== 8'h00) begin
            failures++;
            $display("FAIL t2_eq_thresh got=%h exp=00", active_rings);
        end
        send(6'h05, 10'd511);
        send(6'h05, 10'd494);
        idle(3);
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL t2_count got=%0d exp=1", evq.size());
        end else if (evq[0] !== {3'd0, 6'h05, 10'd511, 8'd1}) begin
            failures++;
            $display("FAIL t2_event got=%h exp=%h", evq[0],
                     {3'd0, 6'h05, 10'd511, 8'd1});
        end
    endtask

    task automatic test_hysteresis();
        evq.delete();
        send(6'h08, 10'd520);
        send(6'h08, 10'd500);
        send(6'h08, 10'd515);
        send(6'h08, 10'd495);
        idle(2);
        checks++;
        if (evq.size() != 0 || active_rings !== 8'h02) begin
            failures++;
            $display("FAIL t3_no_early got=%0d/%h exp=0/02",
                     evq.size(), active_rings);
        end
        send(6'h08, 10'd494);
        idle(3);
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL t3_count got=%0d exp=1", evq.size());
        end else if (evq[0] !== {3'd1, 6'h08, 10'd520, 8'd4}) begin
            failures++;
            $display("FAIL t3_event got=%h exp=%h", evq[0],
                     {3'd1, 6'h08, 10'd520, 8'd4});
        end
    endtask

    task automatic test_interleave();
        evq.delete();
        send(6'h02, 10'd600);
        checks++;
        if (active_rings !== 8'h01) begin
            failures++;
            $display("FAIL t4_act_a got=%h exp=01", active_rings);
        end
        send(6'h3F, 10'd550);
        checks++;
        if (active_rings !== 8'h81) begin
            failures++;
            $display("FAIL t4_act_b got=%h exp=81", active_rings);
        end
        send(6'h02, 10'd700);
        send(6'h3A, 10'd800);
        send(6'h02, 10'd650);
        send(6'h3F, 10'd700);
        send(6'h02, 10'd100);
        checks++;
        if (active_rings !== 8'h80) begin
            failures++;
            $display("FAIL t4_act_c got=%h exp=80", active_rings);
        end
        send(6'h3F, 10'd600);
        send(6'h3F, 10'd0);
        idle(3);
        checks++;
        if (active_rings !== 8'h00) begin
            failures++;
            $display("FAIL t4_act_d got=%h exp=00", active_rings);
        end
        checks++;
        if (evq.size() != 2) begin
            failures++;
            $display("FAIL t4_count got=%0d exp=2", evq.size());
        end else begin
            if (evq[0] !== {3'd0, 6'h02, 10'd700, 8'd3}) begin
                failures++;
                $display("FAIL t4_event0 got=%h exp=%h", evq[0],
                         {3'd0, 6'h02, 10'd700, 8'd3});
            end
            checks++;
            if (evq[1] !== {3'd7, 6'h3A, 10'd800, 8'd4}) begin
                failures++;
                $display("FAIL t4_event1 got=%h exp=%h", evq[1],
                         {3'd7, 6'h3A, 10'd800, 8'd4});
            end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        evq.delete();
        m_ready = 1'b0;
        send(6'h18, 10'd600);
        send(6'h18, 10'd100);
        s_channel = 6'h18;
        s_data    = 10'd700;
        s_valid   = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_ready !== 1'b0 || m_valid !== 1'b1 ||
                {m_ring, m_channel, m_peak, m_width} !==
                {3'd3, 6'h18, 10'd600, 8'd1} ||
                active_rings !== 8'h00) begin
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL t5_hold bad_cycles=%0d exp=0 rdy=%b fields=%h",
                     bad, s_ready, {m_ring, m_channel, m_peak, m_width});
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL t5_release got=%b exp=1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || active_rings !== 8'h08) begin
            failures++;
            $display("FAIL t5_after got=%b/%h exp=0/08",
                     m_valid, active_rings);
        end
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL t5_count got=%0d exp=1", evq.size());
        end else if (evq[0] !== {3'd3, 6'h18, 10'd600, 8'd1}) begin
            failures++;
            $display("FAIL t5_event got=%h exp=%h", evq[0],
                     {3'd3, 6'h18, 10'd600, 8'd1});
        end
        send(6'h18, 10'd0);
        idle(3);
        checks++;
        if (evq.size() != 2) begin
            failures++;
            $display("FAIL t5_next_count got=%0d exp=2", evq.size());
        end else if (evq[1] !== {3'd3, 6'h18, 10'd700, 8'd1}) begin
            failures++;
            $display("FAIL t5_next got=%h exp=%h", evq[1],
                     {3'd3, 6'h18, 10'd700, 8'd1});
        end
    endtask

    task automatic test_saturation_reset();
        evq.delete();
        for (int i = 0; i < 300; i++) send(6'h21, 10'd600);
        send(6'h21, 10'd0);
        idle(3);
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL t6_count got=%0d exp=1", evq.size());
        end else if (evq[0] !== {3'd4, 6'h21, 10'd600, 8'd255}) begin
            failures++;
            $display("FAIL t6_sat got=%h exp=%h", evq[0],
                     {3'd4, 6'h21, 10'd600, 8'd255});
        end
        evq.delete();
        send(6'h28, 10'd600);
        checks++;
        if (active_rings !== 8'h20) begin
            failures++;
            $display("FAIL t6_open got=%h exp=20", active_rings);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || active_rings !== 8'h00 ||
            m_peak !== 10'd0) begin
            failures++;
            $display("FAIL t6_rst got=%b/%h/%0d exp=0/00/0",
                     m_valid, active_rings, m_peak);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        send(6'h28, 10'd0);
        idle(3);
        checks++;
        if (evq.size() != 0 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL t6_no_event got=%0d/%b exp=0/0",
                     evq.size(), m_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_hysteresis();
        test_interleave();
        test_backpressure();
        test_saturation_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
